// File: rtl/mesh_ni.sv
// ---------------------------------------------------------------------------
// mesh_ni
// Network interface between a processing core and the local port (port 0)
// of its mesh router.
//
// TX side: a core request (tx_valid/tx_ready) is packed into one PL-bit flit
// {valid, dest_x, dest_y, [src_x, src_y], payload} (index 0 = valid bit)
// and held on to_router until the router local queue reports
// to_router_avail at a clock edge. One packet per cycle is sustained when the
// router keeps taking them.
//
// RX side: valid flits arriving on from_router are written into an
// RX_DEPTH-entry circular FIFO. The core drains the head with
// rx_valid/rx_ready. A valid flit that arrives while the FIFO is full and
// nothing is popped is dropped and sets the sticky rx_overflow flag.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   router_x, router_y    this node's coordinates
//   tx_valid/tx_ready     core transmit handshake
//   tx_dest_x/y           destination coordinates
//   tx_payload            transmit payload (PW bits)
//   to_router             flit into the router local input
//   to_router_avail       router local queue can take a flit
//   from_router           flit from the router local output
//   from_router_avail     FIFO has room
//   rx_valid/rx_ready     core receive handshake on the FIFO head
//   rx_payload            head payload
//   rx_src_x/y            head source coordinates (0 without source tagging)
//   rx_overflow           sticky drop indicator
//
// Configuration macro: NI_SRC_TAG_EN -- when defined the header carries the
// source coordinates (filled from router_x/router_y) and PW shrinks by
// 2*`CS. `PL (flit width) and `CS (coordinate width) default to 16 and 2
// when not supplied by the surrounding build.
// ---------------------------------------------------------------------------
`ifndef CS
`define CS 2
`endif
`ifndef PL
`define PL 16
`endif

module mesh_ni #(
  parameter int RX_DEPTH = 4,
`ifdef NI_SRC_TAG_EN
  parameter int PW = `PL - 1 - 4 * `CS
`else
  parameter int PW = `PL - 1 - 2 * `CS
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [`CS-1:0]  router_x,
  input  logic [`CS-1:0]  router_y,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic [`CS-1:0]  tx_dest_x,
  input  logic [`CS-1:0]  tx_dest_y,
  input  logic [PW-1:0]   tx_payload,
  output logic [0:`PL-1]  to_router,
  input  logic            to_router_avail,
  input  logic [0:`PL-1]  from_router,
  output logic            from_router_avail,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [PW-1:0]   rx_payload,
  output logic [`CS-1:0]  rx_src_x,
  output logic [`CS-1:0]  rx_src_y,
  output logic            rx_overflow
);

  localparam int CS = `CS;
  localparam int PL = `PL;
  localparam int AW = $clog2(RX_DEPTH);
  // Stored FIFO word: everything after the destination fields.
`ifdef NI_SRC_TAG_EN
  localparam int SW = PW + 2 * CS;
`else
  localparam int SW = PW;
`endif

  // -------------------------------------------------------------------------
  // TX stage 0: flit assembly from the core request
  // -------------------------------------------------------------------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t     tx_state;
  logic [0:PL-1] pkt_p0;
  logic [0:PL-1] pkt_p1;

  always_comb begin
`ifdef NI_SRC_TAG_EN
    pkt_p0 = {1'b1, tx_dest_x, tx_dest_y, router_x, router_y, tx_payload};
`else
    pkt_p0 = {1'b1, tx_dest_x, tx_dest_y, tx_payload};
`endif
  end

  // While holding a flit, a new one may only load on the edge the router
  // takes the current one.
  assign tx_ready = (tx_state == TX_IDLE) | to_router_avail;

  // -------------------------------------------------------------------------
  // TX stage 1: held flit driving the router local input
  // -------------------------------------------------------------------------
  // The held flit is cleared whenever the FSM is idle so to_router shows an
  // idle (all-zero) flit straight out of a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      pkt_p1   <= '0;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            pkt_p1   <= pkt_p0;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (to_router_avail) begin
            if (tx_valid) begin
              pkt_p1 <= pkt_p0;
            end else begin
              pkt_p1   <= '0;
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign to_router = pkt_p1;

  // -------------------------------------------------------------------------
  // RX: receive FIFO
  // -------------------------------------------------------------------------
  logic [SW-1:0] rx_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   rx_count;
  logic          in_vld;
  logic          rx_full;
  logic          rx_push;
  logic          rx_pop;
  logic [SW-1:0] head;

  assign in_vld            = from_router[0];
  // count never exceeds RX_DEPTH (a power of two), so its MSB marks full.
  assign rx_full           = rx_count[AW];
  assign from_router_avail = ~rx_full;
  assign rx_valid          = |rx_count;
  assign rx_pop            = rx_valid & rx_ready;
  // When full, a same-cycle pop frees the slot being written: wr_ptr equals
  // rd_ptr then, and the head is read before the edge overwrites it.
  assign rx_push           = in_vld & (~rx_full | rx_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_push) wr_ptr <= wr_ptr + AW'(1);
      if (rx_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (AW+1)'(1);
        2'b01:   rx_count <= rx_count - (AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
      if (in_vld & rx_full & ~rx_pop) rx_overflow <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[wr_ptr] <= from_router[PL-SW:PL-1];
  end

  assign head       = rx_mem[rd_ptr];
  assign rx_payload = head[PW-1:0];

`ifdef NI_SRC_TAG_EN
  assign rx_src_y = head[PW +: CS];
  assign rx_src_x = head[PW+CS +: CS];
`else
  assign rx_src_x = '0;
  assign rx_src_y = '0;
  logic unused_router;
  assign unused_router = ^{router_x, router_y};
`endif

  // Destination fields are consumed by the router, not by the core.
  logic unused_dest;
  assign unused_dest = ^from_router[1:2*CS];

endmodule

// File: tb/tb_mesh_ni.sv
// ---------------------------------------------------------------------------
// tb_mesh_ni
// Self-checking bench for mesh_ni. A behavioural model (a busy flag plus
// held flit for TX, a queue of received entries for RX) predicts every
// output each cycle; directed scenarios add hand-computed literal values,
// followed by a randomized traffic phase.
// ---------------------------------------------------------------------------
`ifndef CS
`define CS 2
`endif
`ifndef PL
`define PL 16
`endif

module tb_mesh_ni;

  localparam int CS    = `CS;
  localparam int PL    = `PL;
  localparam int DEPTH = 4;
`ifdef NI_SRC_TAG_EN
  localparam int PW  = PL - 1 - 4 * CS;
  localparam bit TAG = 1'b1;
`else
  localparam int PW  = PL - 1 - 2 * CS;
  localparam bit TAG = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CS-1:0]   router_x, router_y;
  logic            tx_valid, tx_ready;
  logic [CS-1:0]   tx_dest_x, tx_dest_y;
  logic [PW-1:0]   tx_payload;
  logic [0:PL-1]   to_router;
  logic            to_router_avail;
  logic [0:PL-1]   from_router;
  logic            from_router_avail;
  logic            rx_valid, rx_ready;
  logic [PW-1:0]   rx_payload;
  logic [CS-1:0]   rx_src_x, rx_src_y;
  logic            rx_overflow;

  mesh_ni #(.RX_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .router_x         (router_x),
    .router_y         (router_y),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_dest_x        (tx_dest_x),
    .tx_dest_y        (tx_dest_y),
    .tx_payload       (tx_payload),
    .to_router        (to_router),
    .to_router_avail  (to_router_avail),
    .from_router      (from_router),
    .from_router_avail(from_router_avail),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .rx_payload       (rx_payload),
    .rx_src_x         (rx_src_x),
    .rx_src_y         (rx_src_y),
    .rx_overflow      (rx_overflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [PW-1:0] pl;
    logic [CS-1:0] sx;
    logic [CS-1:0] sy;
  } ent_t;

  bit            m_busy;
  logic [PL-1:0] m_pkt;
  ent_t          m_q[$];
  bit            m_ovf;

  // current from_router stimulus fields
  bit            fr_v;
  logic [CS-1:0] fr_sx, fr_sy;
  logic [PW-1:0] fr_pl;

  int checks   = 0;
  int failures = 0;

  function automatic logic [PL-1:0] build(input logic v, input logic [CS-1:0] dx,
                                          input logic [CS-1:0] dy, input logic [CS-1:0] sx,
                                          input logic [CS-1:0] sy, input logic [PW-1:0] pl);
`ifdef NI_SRC_TAG_EN
    return {v, dx, dy, sx, sy, pl};
`else
    logic unused_src;
    unused_src = ^{sx, sy};
    return {v, dx, dy, pl};
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_pkt  = '0;
    m_q.delete();
    m_ovf  = 1'b0;
  endtask

  // Compare every DUT output with the model for the current inputs.
  task automatic check_outputs();
    chk("to_router", to_router, m_busy ? m_pkt : '0);
    chk("tx_ready", tx_ready, (!m_busy) || to_router_avail);
    chk("rx_valid", rx_valid, m_q.size() != 0);
    chk("from_router_avail", from_router_avail, m_q.size() < DEPTH);
    chk("rx_overflow", rx_overflow, m_ovf);
    if (m_q.size() != 0) begin
      chk("rx_payload", rx_payload, m_q[0].pl);
      chk("rx_src_x", rx_src_x, TAG ? m_q[0].sx : '0);
      chk("rx_src_y", rx_src_y, TAG ? m_q[0].sy : '0);
    end
  endtask

  // Apply the effects of the coming clock edge to the model.
  task automatic model_update();
    bit   rdy, pop;
    ent_t e;
    rdy = (!m_busy) || to_router_avail;
    pop = (m_q.size() != 0) && rx_ready;
    if (pop) void'(m_q.pop_front());
    if (fr_v) begin
      if (m_q.size() < DEPTH) begin
        e.pl = fr_pl; e.sx = fr_sx; e.sy = fr_sy;
        m_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (tx_valid && rdy) begin
      m_busy = 1'b1;
      m_pkt  = build(1'b1, tx_dest_x, tx_dest_y, router_x, router_y, tx_payload);
    end else if (m_busy && to_router_avail) begin
      m_busy = 1'b0;
    end
  endtask

  // Inputs are changed only right after a falling edge.
  task automatic eval();
    #1;
    check_outputs();
  endtask

  task automatic adv();
    model_update();
    @(negedge clk);
  endtask

  task automatic set_from(input logic v, input logic [CS-1:0] dx, input logic [CS-1:0] dy,
                          input logic [CS-1:0] sx, input logic [CS-1:0] sy,
                          input logic [PW-1:0] pl);
    logic [PL-1:0] junk;
    fr_v = v; fr_sx = sx; fr_sy = sy; fr_pl = pl;
    if (v) begin
      from_router = build(1'b1, dx, dy, sx, sy, pl);
    end else begin
      junk = PL'($urandom);
      junk[PL-1] = 1'b0;
      from_router = junk;
    end
  endtask

  task automatic set_tx(input logic v, input logic [CS-1:0] dx, input logic [CS-1:0] dy,
                        input logic [PW-1:0] pl);
    tx_valid = v; tx_dest_x = dx; tx_dest_y = dy; tx_payload = pl;
  endtask

  task automatic idle_inputs();
    set_tx(1'b0, '0, '0, '0);
    set_from(1'b0, '0, '0, '0, '0, '0);
    to_router_avail = 1'b1;
    rx_ready        = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    router_x = '0;
    router_y = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_fifo(input int first);
    for (int i = 0; i < DEPTH; i++) begin
      set_from(1'b1, 2'(i), 2'(i), 2'(i), 2'(i), PW'(first + i));
      rx_ready = 1'b0;
      eval(); adv();
    end
    set_from(1'b0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    router_x = '0;
    router_y = '0;
    model_reset();

    // ---- reset state ----
    do_reset();
    eval();
    chk("rst_to_router", to_router, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_from_avail", from_router_avail, 1);
    chk("rst_overflow", rx_overflow, 0);
    adv();

    // ---- single injection, dest (2,1), payload 0x5A ----
    set_tx(1'b1, 2'd2, 2'd1, PW'(8'h5A));
    to_router_avail = 1'b1;
    eval();
    chk("t1_tx_ready", tx_ready, 1);
    adv();
    set_tx(1'b0, '0, '0, '0);
    eval();
    chk("t1_to_router", to_router, 64'hC85A);
    adv();
    eval();
    chk("t1_to_router_idle", to_router, 0);
    adv();

    // ---- backpressure for 3 cycles, second packet queued ----
    set_tx(1'b1, 2'd1, 2'd2, PW'(8'h11));
    to_router_avail = 1'b0;
    eval(); adv();
    set_tx(1'b1, 2'd3, 2'd3, PW'(8'h22));
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("t2_hold_pkt", to_router, 64'hB011);
      chk("t2_hold_ready", tx_ready, 0);
      adv();
    end
    to_router_avail = 1'b1;
    eval();
    chk("t2_release_ready", tx_ready, 1);
    adv();
    set_tx(1'b0, '0, '0, '0);
    to_router_avail = 1'b0;
    eval();
    chk("t2_second_pkt", to_router, 64'hF822);
    to_router_avail = 1'b1;
    eval(); adv();

    // ---- FIFO fill, overflow, in-order drain ----
    do_reset();
    fill_fifo(1);
    eval();
    chk("t3_full_avail", from_router_avail, 0);
    chk("t3_no_ovf_yet", rx_overflow, 0);
    set_from(1'b1, '0, '0, '0, '0, PW'(5));
    eval(); adv();
    set_from(1'b0, '0, '0, '0, '0, '0);
    eval();
    chk("t3_overflow", rx_overflow, 1);
    for (int i = 1; i <= DEPTH; i++) begin
      rx_ready = 1'b1;
      eval();
      chk("t3_pop_order", rx_payload, i);
      adv();
    end
    rx_ready = 1'b0;
    eval();
    chk("t3_empty", rx_valid, 0);
    adv();

    // ---- full FIFO, simultaneous push and pop ----
    do_reset();
    fill_fifo(1);
    set_from(1'b1, '0, '0, '0, '0, PW'(5));
    rx_ready = 1'b1;
    eval();
    chk("t4_head_before", rx_payload, 1);
    adv();
    set_from(1'b0, '0, '0, '0, '0, '0);
    rx_ready = 1'b0;
    eval();
    chk("t4_still_full", from_router_avail, 0);
    chk("t4_no_overflow", rx_overflow, 0);
    for (int i = 2; i <= DEPTH + 1; i++) begin
      rx_ready = 1'b1;
      eval();
      chk("t4_pop_order", rx_payload, i);
      adv();
    end
    rx_ready = 1'b0;

    // ---- asynchronous reset while sending with 2 FIFO entries ----
    do_reset();
    set_tx(1'b1, 2'd1, 2'd1, PW'(8'h44));
    to_router_avail = 1'b0;
    set_from(1'b1, '0, '0, '0, '0, PW'(7));
    eval(); adv();
    set_tx(1'b0, '0, '0, '0);
    set_from(1'b1, '0, '0, '0, '0, PW'(8));
    eval(); adv();
    set_from(1'b0, '0, '0, '0, '0, '0);
    eval();
    chk("t5_pre_valid", rx_valid, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_to_router", to_router, 0);
    chk("t5_rx_valid", rx_valid, 0);
    chk("t5_from_avail", from_router_avail, 1);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    to_router_avail = 1'b1;

    // ---- self-addressed packet from router (3,0) ----
    router_x = 2'd3;
    router_y = 2'd0;
    set_tx(1'b1, 2'd3, 2'd0, PW'(8'h33));
    eval(); adv();
    set_tx(1'b0, '0, '0, '0);
    set_from(1'b1, 2'd3, 2'd0, 2'd3, 2'd0, PW'(8'h33));
    eval(); adv();
    set_from(1'b0, '0, '0, '0, '0, '0);
    eval();
    chk("t6_rx_valid", rx_valid, 1);
    chk("t6_payload", rx_payload, 8'h33);
    chk("t6_src_x", rx_src_x, TAG ? 3 : 0);
    chk("t6_src_y", rx_src_y, 0);
    rx_ready = 1'b1;
    eval(); adv();
    rx_ready = 1'b0;

    // ---- randomized traffic ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      router_x = CS'($urandom);
      router_y = CS'($urandom);
      set_tx(($urandom_range(0, 9) < 6), CS'($urandom), CS'($urandom), PW'($urandom));
      to_router_avail = ($urandom_range(0, 9) < 7);
      rx_ready = ($urandom_range(0, 9) < 4);
      set_from(($urandom_range(0, 9) < 5), CS'($urandom), CS'($urandom),
               CS'($urandom), CS'($urandom), PW'($urandom));
      eval(); adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesh_ni.md
# mesh_ni

Network interface between a processing core and the local port (port 0) of its mesh router. It packs core transmit requests into single-flit `PL`-bit packets and injects them under the router queue's availability signal. It also accepts packets the router delivers to the local port into a small receive FIFO that the core drains with a valid/ready handshake. It is the injection and ejection stage directly adjacent to the router's local queue and its XY output.

## Interface
Parameters:
- RX_DEPTH, 4, receive FIFO depth in packets; power of two, ≥ 2.
- PW, `PL-1-2*`CS` (minus a further 2*`CS` with NI_SRC_TAG_EN), payload width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous and active-low.
- router_x, router_y  in  `CS` each  this node's coordinates.
- tx_valid  in  1  core has a packet to send.
- tx_ready  out  1  NI accepts the packet this cycle.
- tx_dest_x, tx_dest_y  in  `CS` each  destination coordinates.
- tx_payload  in  PW  payload.
- to_router  out  [0:`PL-1]  packet into the router local input.
- to_router_avail  in  1  router local queue can take a packet.
- from_router  in  [0:`PL-1]  packet from the router local output.
- from_router_avail  out  1  NI can take a packet.
- rx_valid  out  1  FIFO head valid.
- rx_ready  in  1  core pops the head.
- rx_payload  out  PW  head payload.
- rx_src_x, rx_src_y  out  `CS` each  head source coordinates.
- rx_overflow  out  1  sticky; set when a valid packet is dropped.

## Operation
- Packet layout (MSB-first index):
  - bit 0: valid.
  - bits 1..`CS`: dest X.
  - next `CS` bits: dest Y.
  - With NI_SRC_TAG_EN: src X, then src Y.
  - Remaining bits: payload.
  - Packets with bit 0 = 0 are idle and are ignored everywhere.
- TX FSM has two states, IDLE and SEND.
  - IDLE: to_router is all zeros; tx_ready = 1. On a handshake (tx_valid & tx_ready), the packet register loads {1, dest, [src], payload} and the FSM moves to SEND.
  - SEND: to_router holds the packet register. At a posedge where to_router_avail = 1, the router captures the packet.
  - tx_ready = to_router_avail while in SEND, so a new packet loads on the same edge (back-to-back, one packet per cycle). Without a new packet the FSM returns to IDLE.
  - The packet stays stable while to_router_avail = 0.
- Self-addressed packets (dest = router_x/router_y) are injected normally; the router returns them on its local output.
- RX FIFO: circular buffer of RX_DEPTH entries with wrap-around pointers and a count of log2(RX_DEPTH)+1 bits.
  - from_router_avail = (count < RX_DEPTH), combinational from count.
  - Push when from_router bit 0 = 1 and (count < RX_DEPTH or the pop is active this cycle).
  - Pop when rx_valid & rx_ready; rx_valid = (count != 0).
  - rx_* fields are decoded combinationally from the head entry.
  - Simultaneous push and pop: count is unchanged; both take effect. This also applies when the FIFO is full.
  - A valid packet that arrives while full with no pop is dropped and sets rx_overflow. The flag clears only on reset.

## Timing
- Reset values:
  - TX state IDLE, to_router = 0, tx_ready = 1.
  - FIFO empty, rx_valid = 0, from_router_avail = 1, rx_overflow = 0.
  - rx_payload and rx_src are undefined when rx_valid = 0.
- Reset asserted mid-operation discards any held TX packet and all FIFO contents. No partial packet is emitted after reset.
- TX latency: handshake at edge N → to_router valid during cycle N+1. Capture occurs at the first edge ≥ N+1 with to_router_avail = 1.
- RX latency: packet on from_router at edge N → rx_valid during cycle N+1 if the FIFO was empty.
- All outputs derive from registers, except tx_ready, from_router_avail and rx_* (combinational from registers and to_router_avail).

## Configuration
- NI_SRC_TAG_EN defined:
  - The header carries source X/Y; TX fills them from router_x/router_y.
  - rx_src_x/rx_src_y decode them.
  - PW shrinks by 2*`CS`.
- NI_SRC_TAG_EN undefined:
  - No source field.
  - rx_src_x/rx_src_y are tied to 0.

## Test plan
- Reset, then tx_valid with dest (2,1) and payload 0x5A, to_router_avail = 1 → tx_ready = 1; the next cycle to_router = {1, 2, 1, 0x5A}; the following cycle to_router = 0.
- to_router_avail held 0 for 3 cycles after injection → to_router is stable for 3 cycles and tx_ready = 0; avail rises → capture, and a second queued tx loads on the same edge.
- 4 valid packets pushed with rx_ready = 0 and RX_DEPTH = 4 → from_router_avail drops after the 4th; a 5th packet → dropped and rx_overflow = 1; popping returns payloads in order 1, 2, 3, 4.
- Full FIFO, push and pop in the same cycle → count stays 4, the new packet lands at the tail, rx_overflow stays 0.
- rst_n pulsed low asynchronously while in SEND with 2 FIFO entries → to_router = 0, rx_valid = 0, from_router_avail = 1 immediately.
- With NI_SRC_TAG_EN and router (3,0) sending to self → the received packet has rx_src_x = 3 and rx_src_y = 0.
